// File: rtl/dnn_pkg.sv
// dnn_pkg: shared fixed-point types, constants, state encoding and the ReLU helper.
package dnn_pkg;
    typedef logic signed [15:0] fxp_t;
    localparam int FXP_FRAC_BITS = 8;
    localparam fxp_t FXP_MIN = 16'sh8000;
    typedef enum logic {IDLE, SEND} ser_state_t;
    function automatic fxp_t relu(fxp_t v);
        return v[15] ? '0 : v;
    endfunction
endpackage

// File: rtl/layer_output_serializer_argmax_tracker.sv
// argmax_tracker: running signed max over a stream of beats; reports the index of the max.
// Ports: clk, rst_n (async active-low), clear (restart tracking), update (beat accepted),
//        value (current beat), max_idx (argmax including the current beat, combinational).
module argmax_tracker
    import dnn_pkg::*;
#(
    parameter int COUNT = 15,
    localparam int IDX_W = COUNT > 1 ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  fxp_t             value,
    output logic [IDX_W-1:0] max_idx
);
    fxp_t             max_q;
    logic [IDX_W-1:0] max_idx_q;
    logic [IDX_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            max_q     <= FXP_MIN;
            max_idx_q <= '0;
            cnt       <= '0;
        end else if (update) begin
            if (value > max_q) begin
                max_q     <= value;
                max_idx_q <= cnt;
            end
            cnt <= cnt + 1'b1;
        end
    end

    // Strict compare keeps the lower index on ties.
    always_comb max_idx = (value > max_q) ? cnt : max_idx_q;
endmodule

// File: rtl/layer_output_serializer.sv
// layer_output_serializer: captures a parallel layer result vector and streams it one neuron per beat.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data (vector capture handshake);
//        out_valid/out_ready/out_data/out_index/out_last (beat stream); out_argmax (valid on last beat).
// Build option: define LAYER_OUT_RELU_EN to apply ReLU to every value at capture.
module layer_output_serializer
    import dnn_pkg::*;
#(
    parameter int OUTPUT_NEURON_COUNT = 15,
    localparam int IDX_W = OUTPUT_NEURON_COUNT > 1 ? $clog2(OUTPUT_NEURON_COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data [OUTPUT_NEURON_COUNT],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [IDX_W-1:0] out_argmax
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NEURON_COUNT - 1);

    ser_state_t       state, state_nxt;
    fxp_t             buf_q [OUTPUT_NEURON_COUNT];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] max_idx;
    logic             capture;
    logic             fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A capture on the last beat keeps the stream in SEND with no bubble.
    always_comb state_nxt = capture ? SEND : (fire && out_last) ? IDLE : state;

    always_comb begin
        out_valid  = state == SEND;
        out_last   = out_valid && idx == LAST_IDX;
        out_data   = out_valid ? buf_q[idx] : '0;
        out_index  = idx;
        out_argmax = out_valid ? max_idx : '0;
        fire       = out_valid && out_ready;
        in_ready   = !out_valid || (out_last && out_ready);
        capture    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int i = 0; i < OUTPUT_NEURON_COUNT; i++) buf_q[i] <= '0;
        end else begin
            if (capture || (fire && out_last)) idx <= '0;
            else if (fire)                     idx <= idx + 1'b1;
            if (capture)
                for (int i = 0; i < OUTPUT_NEURON_COUNT; i++)
`ifdef LAYER_OUT_RELU_EN
                    buf_q[i] <= relu(in_data[i]);
`else
                    buf_q[i] <= in_data[i];
`endif
        end
    end

    argmax_tracker #(.COUNT(OUTPUT_NEURON_COUNT)) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (capture),
        .update  (fire),
        .value   (out_data),
        .max_idx (max_idx)
    );
endmodule

// File: tb/tb_layer_output_serializer.sv
// tb_layer_output_serializer: directed checks of the serializer with a 4-neuron and a 1-neuron instance.
module tb_layer_output_serializer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1, out_last;
    logic [15:0] in_data [4] = '{default: '0};
    logic [15:0] out_data;
    logic [1:0]  out_index, out_argmax;
    logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1, out_last1;
    logic [15:0] in_data1 [1] = '{default: '0};
    logic [15:0] out_data1;
    logic [0:0]  out_index1, out_argmax1;
    int          total = 0, pass = 0;

    logic [15:0] va [4] = '{16'h0100, 16'h0300, 16'h0200, 16'h0050};
    logic [15:0] vb [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0400};

    always #5 clk = ~clk;

    layer_output_serializer #(.OUTPUT_NEURON_COUNT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .out_argmax(out_argmax));

    layer_output_serializer #(.OUTPUT_NEURON_COUNT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_index(out_index1),
        .out_last(out_last1), .out_argmax(out_argmax1));

    task automatic test_reset();
        @(negedge clk);
        total++; if ({out_valid, out_data, out_index, out_last, out_argmax} !== '0) $display("FAIL reset_outputs got v=%b d=%h i=%0d l=%b a=%0d exp all 0", out_valid, out_data, out_index, out_last, out_argmax); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass++;
        total++; if ({out_valid1, out_data1, out_index1, out_last1, out_argmax1} !== '0) $display("FAIL reset_outputs_n1 got v=%b d=%h exp 0", out_valid1, out_data1); else pass++;
        rst_n = 1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_data = va; in_valid = 1; out_ready = 1;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b exp 1", in_ready); else pass++;
        @(negedge clk);
        in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_index !== 2'(k) || out_data !== va[k] || out_last !== (k == 3)) $display("FAIL basic_beat%0d got v=%b i=%0d d=%h l=%b exp v=1 i=%0d d=%h l=%b", k, out_valid, out_index, out_data, out_last, k, va[k], k == 3); else pass++;
            if (k == 3) begin
                total++; if (out_argmax !== 2'd1) $display("FAIL basic_argmax got %0d exp 1", out_argmax); else pass++;
            end
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL basic_idle got out_valid=%b exp 0", out_valid); else pass++;
    endtask

    task automatic test_stall();
        logic [15:0] pat = 16'b1111_1101_1010_1001;
        int k = 0;
        @(negedge clk);
        in_data = va; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int c = 0; c < 16 && k < 4; c++) begin
            out_ready = pat[c];
            total++; if (out_valid !== 1'b1 || out_index !== 2'(k) || out_data !== va[k]) $display("FAIL stall_cycle%0d got v=%b i=%0d d=%h exp v=1 i=%0d d=%h", c, out_valid, out_index, out_data, k, va[k]); else pass++;
            if (out_ready) k++;
            @(negedge clk);
        end
        out_ready = 1;
        total++; if (k !== 4 || out_valid !== 1'b0) $display("FAIL stall_done got beats=%0d v=%b exp beats=4 v=0", k, out_valid); else pass++;
    endtask

    task automatic test_relu();
        logic [15:0] v [4] = '{16'hFF00, 16'h0080, 16'h0080, 16'hFE00};
`ifdef LAYER_OUT_RELU_EN
        logic [15:0] e [4] = '{16'h0000, 16'h0080, 16'h0080, 16'h0000};
`else
        logic [15:0] e [4] = '{16'hFF00, 16'h0080, 16'h0080, 16'hFE00};
`endif
        @(negedge clk);
        in_data = v; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== e[k]) $display("FAIL relu_beat%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, e[k]); else pass++;
            if (k == 3) begin
                total++; if (out_argmax !== 2'd1) $display("FAIL relu_argmax got %0d exp 1", out_argmax); else pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e [8] = '{16'h0100, 16'h0300, 16'h0200, 16'h0050, 16'h0010, 16'h0020, 16'h0030, 16'h0400};
        @(negedge clk);
        in_data = va; in_valid = 1;
        @(negedge clk);
        in_data = vb;
        for (int k = 0; k < 8; k++) begin
            total++; if (out_valid !== 1'b1 || out_index !== 2'(k % 4) || out_data !== e[k] || in_ready !== (k % 4 == 3)) $display("FAIL b2b_beat%0d got v=%b i=%0d d=%h rdy=%b exp v=1 i=%0d d=%h rdy=%b", k, out_valid, out_index, out_data, in_ready, k % 4, e[k], k % 4 == 3); else pass++;
            if (k == 3) begin
                total++; if (out_argmax !== 2'd1) $display("FAIL b2b_argmax0 got %0d exp 1", out_argmax); else pass++;
            end
            if (k == 7) begin
                total++; if (out_argmax !== 2'd3) $display("FAIL b2b_argmax1 got %0d exp 3", out_argmax); else pass++;
            end
            if (k == 4) in_valid = 0;
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got out_valid=%b exp 0", out_valid); else pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_data = va; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        total++; if (out_index !== 2'd1 || out_data !== va[1]) $display("FAIL rstmid_beat1 got i=%0d d=%h exp i=1 d=%h", out_index, out_data, va[1]); else pass++;
        @(negedge clk);
        rst_n = 0;
        #1;
        total++; if ({out_valid, out_data, out_index, out_last} !== '0 || in_ready !== 1'b1) $display("FAIL rstmid_async got v=%b d=%h i=%0d l=%b rdy=%b exp 0/0/0/0/1", out_valid, out_data, out_index, out_last, in_ready); else pass++;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_quiet%0d got v=%b rdy=%b exp v=0 rdy=1", c, out_valid, in_ready); else pass++;
        end
        in_data = vb; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_index !== 2'(k) || out_data !== vb[k]) $display("FAIL rstmid_new%0d got v=%b i=%0d d=%h exp v=1 i=%0d d=%h", k, out_valid, out_index, out_data, k, vb[k]); else pass++;
            if (k == 3) begin
                total++; if (out_argmax !== 2'd3) $display("FAIL rstmid_argmax got %0d exp 3", out_argmax); else pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
`ifdef LAYER_OUT_RELU_EN
        logic [15:0] e = 16'h0000;
`else
        logic [15:0] e = 16'h8000;
`endif
        @(negedge clk);
        in_data1[0] = 16'h8000; in_valid1 = 1;
        @(negedge clk);
        in_valid1 = 0;
        total++; if (out_valid1 !== 1'b1 || out_last1 !== 1'b1 || out_index1 !== 1'b0 || out_data1 !== e) $display("FAIL n1_beat got v=%b l=%b i=%0d d=%h exp v=1 l=1 i=0 d=%h", out_valid1, out_last1, out_index1, out_data1, e); else pass++;
        total++; if (out_argmax1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL n1_argmax got a=%0d rdy=%b exp a=0 rdy=1", out_argmax1, in_ready1); else pass++;
        @(negedge clk);
        total++; if (out_valid1 !== 1'b0) $display("FAIL n1_idle got out_valid=%b exp 0", out_valid1); else pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_relu();
        test_back_to_back();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
